tlb: RTL

- Fully associative LoongArch TLB array that sits directly upstream of the virtual-to-physical address translation stage.
- Provides two combinational search ports: s0 for instruction fetch, s1 for load/store. The translation stage drives vppn/va_bit12/asid on a port and consumes found/index/ppn/ps/plv/mat/d/v from it.
- Also provides one synchronous write port (TLBWR/TLBFILL), one combinational read port (TLBRD), and a synchronous INVTLB engine.

---
 rtl/tlb_pkg.sv | 34 +++
 rtl/tlb_if.sv | 36 +++
 rtl/tlb_entry_match.sv | 31 +++
 rtl/tlb.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlb_pkg
// Description : Shared constants and types for the LoongArch TLB array:
//               default entry count, page-size encodings, INVTLB op codes
//               and the per-page payload struct.
// Revision    : 1.0 - initial release
// ============================================================================
package tlb_pkg;

    localparam int TLBNUM_DEFAULT = 16;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_4M = 6'd21;

    localparam logic [4:0] INV_ALL0     = 5'd0;
    localparam logic [4:0] INV_ALL1     = 5'd1;
    localparam logic [4:0] INV_G1       = 5'd2;
    localparam logic [4:0] INV_G0       = 5'd3;
    localparam logic [4:0] INV_ASID     = 5'd4;
    localparam logic [4:0] INV_ASID_VA  = 5'd5;
    localparam logic [4:0] INV_GASID_VA = 5'd6;

    // One half (even or odd page) of an entry.
    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_page_t;

endpackage
`default_nettype wire

// File: rtl/tlb_if.sv
`default_nettype none
// ============================================================================
// Module      : tlb_search_if
// Description : One TLB search port. The translation stage (master) drives
//               vppn/va_bit12/asid; the TLB (slave) returns the hit result
//               and the selected page attributes.
// Ports       : vppn[18:0], va_bit12, asid[9:0]         master -> slave
//               found, index, ppn, ps, plv, mat, d, v   slave -> master
// Revision    : 1.0 - initial release
// ============================================================================
interface tlb_search_if #(
    parameter int IDXW = 4
);
    logic [18:0]     vppn;
    logic            va_bit12;
    logic [9:0]      asid;
    logic            found;
    logic [IDXW-1:0] index;
    logic [19:0]     ppn;
    logic [5:0]      ps;
    logic [1:0]      plv;
    logic [1:0]      mat;
    logic            d;
    logic            v;

    modport master (
        output vppn, va_bit12, asid,
        input  found, index, ppn, ps, plv, mat, d, v
    );

    modport slave (
        input  vppn, va_bit12, asid,
        output found, index, ppn, ps, plv, mat, d, v
    );
endinterface
`default_nettype wire

// File: rtl/tlb_entry_match.sv
`default_nettype none
// ============================================================================
// Module      : tlb_entry_match
// Description : Compare of one TLB entry against a search key.
//               va_match : VPPN compare, honouring 4MB pages (low 9 bits
//                          ignored when ps4m=1). Independent of E and ASID.
//               hit      : va_match qualified by E and (G or ASID equal).
// Ports       : e, g, asid, vppn, ps4m   stored entry fields
//               s_vppn, s_asid           search key
//               hit, va_match            compare results
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_entry_match (
    input  wire logic        e,
    input  wire logic        g,
    input  wire logic [9:0]  asid,
    input  wire logic [18:0] vppn,
    input  wire logic        ps4m,
    input  wire logic [18:0] s_vppn,
    input  wire logic [9:0]  s_asid,
    output logic             hit,
    output logic             va_match
);

    assign va_match = (vppn[18:9] == s_vppn[18:9]) &&
                      (ps4m || (vppn[8:0] == s_vppn[8:0]));

    assign hit = e && va_match && (g || (asid == s_asid));

endmodule
`default_nettype wire

// File: rtl/tlb.sv
`default_nettype none
// ============================================================================
// Module      : tlb
// Description : Fully associative LoongArch TLB. Two combinational search
//               ports (s0 fetch, s1 load/store), synchronous write port,
//               combinational read port and single-cycle INVTLB engine.
// Ports       : clk, resetn (async, active low)
//               s0, s1          search interfaces (slave side)
//               invtlb_valid/op INVTLB request, operands on s1.asid/s1.vppn
//               we, w_index, w_* write port
//               r_index, r_*    read port
// Revision    : 1.0 - initial release
// ============================================================================
module tlb
    import tlb_pkg::*;
#(
    parameter int TLBNUM = TLBNUM_DEFAULT,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  wire logic            clk,
    input  wire logic            resetn,
    tlb_search_if.slave          s0,
    tlb_search_if.slave          s1,
    input  wire logic            invtlb_valid,
    input  wire logic [4:0]      invtlb_op,
    input  wire logic            we,
    input  wire logic [IDXW-1:0] w_index,
    input  wire logic            w_e,
    input  wire logic            w_g,
    input  wire logic [18:0]     w_vppn,
    input  wire logic [5:0]      w_ps,
    input  wire logic [9:0]      w_asid,
    input  wire logic [19:0]     w_ppn0,
    input  wire logic [1:0]      w_plv0,
    input  wire logic [1:0]      w_mat0,
    input  wire logic            w_d0,
    input  wire logic            w_v0,
    input  wire logic [19:0]     w_ppn1,
    input  wire logic [1:0]      w_plv1,
    input  wire logic [1:0]      w_mat1,
    input  wire logic            w_d1,
    input  wire logic            w_v1,
    input  wire logic [IDXW-1:0] r_index,
    output logic                 r_e,
    output logic                 r_g,
    output logic [18:0]          r_vppn,
    output logic [5:0]           r_ps,
    output logic [9:0]           r_asid,
    output logic [19:0]          r_ppn0,
    output logic [1:0]           r_plv0,
    output logic [1:0]           r_mat0,
    output logic                 r_d0,
    output logic                 r_v0,
    output logic [19:0]          r_ppn1,
    output logic [1:0]           r_plv1,
    output logic [1:0]           r_mat1,
    output logic                 r_d1,
    output logic                 r_v1
);

    // Entry storage
    logic        r_ent_e    [TLBNUM];
    logic        r_ent_g    [TLBNUM];
    logic [9:0]  r_ent_asid [TLBNUM];
    logic [18:0] r_ent_vppn [TLBNUM];
    logic        r_ent_ps4m [TLBNUM];
    tlb_page_t   r_ent_p0   [TLBNUM];
    tlb_page_t   r_ent_p1   [TLBNUM];

    logic [TLBNUM-1:0] w_s0_hit;
    logic [TLBNUM-1:0] w_s1_hit;
    logic [TLBNUM-1:0] w_s1_va;
    // Nothing consumes the VA-only compare of the fetch port.
    logic [TLBNUM-1:0] w_s0_va_unused;

    for (genvar i = 0; i < TLBNUM; i++) begin : g_match
        tlb_entry_match u_s0_match (
            .e        (r_ent_e[i]),
            .g        (r_ent_g[i]),
            .asid     (r_ent_asid[i]),
            .vppn     (r_ent_vppn[i]),
            .ps4m     (r_ent_ps4m[i]),
            .s_vppn   (s0.vppn),
            .s_asid   (s0.asid),
            .hit      (w_s0_hit[i]),
            .va_match (w_s0_va_unused[i])
        );
        tlb_entry_match u_s1_match (
            .e        (r_ent_e[i]),
            .g        (r_ent_g[i]),
            .asid     (r_ent_asid[i]),
            .vppn     (r_ent_vppn[i]),
            .ps4m     (r_ent_ps4m[i]),
            .s_vppn   (s1.vppn),
            .s_asid   (s1.asid),
            .hit      (w_s1_hit[i]),
            .va_match (w_s1_va[i])
        );
    end

    // Priority encode: scanning downward lets the lowest hitting index win.
    logic            w_s0_found;
    logic [IDXW-1:0] w_s0_idx;
    logic            w_s1_found;
    logic [IDXW-1:0] w_s1_idx;

    always_comb begin
        w_s0_found = 1'b0;
        w_s0_idx   = '0;
        w_s1_found = 1'b0;
        w_s1_idx   = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (w_s0_hit[i]) begin
                w_s0_found = 1'b1;
                w_s0_idx   = IDXW'(i);
            end
            if (w_s1_hit[i]) begin
                w_s1_found = 1'b1;
                w_s1_idx   = IDXW'(i);
            end
        end
    end

    // Odd-page select: a 4MB page splits on VA[21] (vppn[8]), a 4KB page on VA[12].
    logic      w_s0_odd;
    logic      w_s1_odd;
    tlb_page_t w_s0_page;
    tlb_page_t w_s1_page;

    assign w_s0_odd  = r_ent_ps4m[w_s0_idx] ? s0.vppn[8] : s0.va_bit12;
    assign w_s1_odd  = r_ent_ps4m[w_s1_idx] ? s1.vppn[8] : s1.va_bit12;
    assign w_s0_page = !w_s0_found ? '0 : (w_s0_odd ? r_ent_p1[w_s0_idx] : r_ent_p0[w_s0_idx]);
    assign w_s1_page = !w_s1_found ? '0 : (w_s1_odd ? r_ent_p1[w_s1_idx] : r_ent_p0[w_s1_idx]);

    assign s0.found = w_s0_found;
    assign s0.index = w_s0_idx;
    assign s0.ppn   = w_s0_page.ppn;
    assign s0.plv   = w_s0_page.plv;
    assign s0.mat   = w_s0_page.mat;
    assign s0.d     = w_s0_page.d;
    assign s0.v     = w_s0_page.v;
    assign s0.ps    = !w_s0_found ? 6'd0 : (r_ent_ps4m[w_s0_idx] ? PS_4M : PS_4K);

    assign s1.found = w_s1_found;
    assign s1.index = w_s1_idx;
    assign s1.ppn   = w_s1_page.ppn;
    assign s1.plv   = w_s1_page.plv;
    assign s1.mat   = w_s1_page.mat;
    assign s1.d     = w_s1_page.d;
    assign s1.v     = w_s1_page.v;
    assign s1.ps    = !w_s1_found ? 6'd0 : (r_ent_ps4m[w_s1_idx] ? PS_4M : PS_4K);

    // INVTLB victim selection; operands come from the s1 search key.
    logic [TLBNUM-1:0] w_inv;

    always_comb begin
        w_inv = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            case (invtlb_op)
                INV_ALL0,
                INV_ALL1:     w_inv[i] = 1'b1;
                INV_G1:       w_inv[i] = r_ent_g[i];
                INV_G0:       w_inv[i] = !r_ent_g[i];
                INV_ASID:     w_inv[i] = !r_ent_g[i] && (r_ent_asid[i] == s1.asid);
                INV_ASID_VA:  w_inv[i] = !r_ent_g[i] && (r_ent_asid[i] == s1.asid) && w_s1_va[i];
                INV_GASID_VA: w_inv[i] = (r_ent_g[i] || (r_ent_asid[i] == s1.asid)) && w_s1_va[i];
                default:      w_inv[i] = 1'b0;
            endcase
        end
        if (!invtlb_valid) begin
            w_inv = '0;
        end
    end

    // A write to an entry takes precedence over invalidating that same entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TLBNUM; i++) begin
                r_ent_e[i]    <= 1'b0;
                r_ent_g[i]    <= 1'b0;
                r_ent_asid[i] <= '0;
                r_ent_vppn[i] <= '0;
                r_ent_ps4m[i] <= 1'b0;
                r_ent_p0[i]   <= '0;
                r_ent_p1[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < TLBNUM; i++) begin
                if (we && (w_index == IDXW'(i))) begin
                    r_ent_e[i]    <= w_e;
                    r_ent_g[i]    <= w_g;
                    r_ent_asid[i] <= w_asid;
                    r_ent_vppn[i] <= w_vppn;
                    r_ent_ps4m[i] <= (w_ps == PS_4M);
                    r_ent_p0[i]   <= '{ppn: w_ppn0, plv: w_plv0, mat: w_mat0, d: w_d0, v: w_v0};
                    r_ent_p1[i]   <= '{ppn: w_ppn1, plv: w_plv1, mat: w_mat1, d: w_d1, v: w_v1};
                end else if (w_inv[i]) begin
                    r_ent_e[i] <= 1'b0;
                end
            end
        end
    end

    assign r_e    = r_ent_e[r_index];
    assign r_g    = r_ent_g[r_index];
    assign r_vppn = r_ent_vppn[r_index];
    assign r_asid = r_ent_asid[r_index];
    assign r_ps   = r_ent_ps4m[r_index] ? PS_4M : PS_4K;
    assign r_ppn0 = r_ent_p0[r_index].ppn;
    assign r_plv0 = r_ent_p0[r_index].plv;
    assign r_mat0 = r_ent_p0[r_index].mat;
    assign r_d0   = r_ent_p0[r_index].d;
    assign r_v0   = r_ent_p0[r_index].v;
    assign r_ppn1 = r_ent_p1[r_index].ppn;
    assign r_plv1 = r_ent_p1[r_index].plv;
    assign r_mat1 = r_ent_p1[r_index].mat;
    assign r_d1   = r_ent_p1[r_index].d;
    assign r_v1   = r_ent_p1[r_index].v;

endmodule
`default_nettype wire
